// File: rtl/mul_div_sequencer_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer:
// ALU opcodes, FSM state encodings and operation selects.
package mul_div_sequencer_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mul_div_sequencer.sv
// Shift-add multiplier and restoring divider that borrows the shared
// ALU for every add, subtract and zero test, one operation per cycle.
module mul_div_sequencer
    import mul_div_sequencer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             alu_req,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [3:0]       ALUOperation,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             Zero
);

    logic [1:0]           state;
    logic                 op_q;
    logic [WIDTH-1:0]     opnd;
    logic [CNT_WIDTH-1:0] count;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 dz_q;

    logic [WIDTH-1:0] rs;
    logic             carry;
    logic             borrow;
    logic             accept;

    // Partial remainder shifted left by one; its lost msb forces accept.
    assign rs     = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign carry  = ALUResult < hi_q;
    assign borrow = ALUResult > rs;
    assign accept = hi_q[WIDTH-1] | ~borrow;

    assign busy        = state != S_IDLE;
    assign alu_req     = busy;
    assign done        = state == S_DONE;
    assign div_by_zero = dz_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

    always_comb begin
        ALUOperation = ALU_AND;
        ALU_A        = '0;
        ALU_B        = '0;
        unique case (state)
            S_CHECK: begin
                ALUOperation = ALU_OR;
                ALU_A        = opnd;
            end
            S_RUN: begin
                if (op_q == OP_MUL) begin
                    ALUOperation = ALU_ADD;
                    ALU_A        = hi_q;
                    ALU_B        = lo_q[0] ? opnd : '0;
                end else begin
                    ALUOperation = ALU_SUB;
                    ALU_A        = rs;
                    ALU_B        = opnd;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= OP_MUL;
            opnd  <= '0;
            count <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dz_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        opnd  <= operand_b;
                        hi_q  <= '0;
                        lo_q  <= operand_a;
                        dz_q  <= 1'b0;
                        count <= CNT_WIDTH'(WIDTH);
                        state <= (op == OP_DIV) ? S_CHECK : S_RUN;
                    end
                end
                S_CHECK: begin
                    if (Zero) begin
                        hi_q  <= lo_q;
                        lo_q  <= '1;
                        dz_q  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (op_q == OP_MUL) begin
                        {hi_q, lo_q} <= {carry, ALUResult, lo_q[WIDTH-1:1]};
                    end else begin
                        hi_q <= accept ? ALUResult : rs;
                        lo_q <= {lo_q[WIDTH-2:0], accept};
                    end
                    count <= count - 1'b1;
                    if (count == CNT_WIDTH'(1)) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer with a behavioural ALU
// and an arithmetic reference model for products and quotients.
module tb_mul_div_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        alu_req;
    logic        done;
    logic        div_by_zero;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [3:0]  ALUOperation;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [31:0] ALUResult;
    logic        Zero;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mul_div_sequencer #(.WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .busy(busy),
        .alu_req(alu_req),
        .done(done),
        .div_by_zero(div_by_zero),
        .HI(HI),
        .LO(LO),
        .ALUOperation(ALUOperation),
        .ALU_A(ALU_A),
        .ALU_B(ALU_B),
        .ALUResult(ALUResult),
        .Zero(Zero)
    );

    // Shared combinational ALU
    always_comb begin
        ALUResult = '0;
        case (ALUOperation)
            4'b0000: ALUResult = ALU_A & ALU_B;
            4'b0001: ALUResult = ALU_A | ALU_B;
            4'b0010: ALUResult = ~(ALU_A | ALU_B);
            4'b0011: ALUResult = ALU_A + ALU_B;
            4'b0100: ALUResult = ALU_A - ALU_B;
            default: ALUResult = '0;
        endcase
        Zero = ALUResult == 32'd0;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic o, input int p1, input int p2);
        logic [63:0] prod;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        int          exp_dc;
        int          dc;
        if (o == 1'b0) begin
            prod   = 64'(a) * 64'(b);
            eh     = prod[63:32];
            el     = prod[31:0];
            ez     = 1'b0;
            exp_dc = 33;
        end else if (b == 32'd0) begin
            eh     = a;
            el     = 32'hFFFF_FFFF;
            ez     = 1'b1;
            exp_dc = 2;
        end else begin
            eh     = a % b;
            el     = a / b;
            ez     = 1'b0;
            exp_dc = 34;
        end
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        dc        = -1;
        for (int c = 1; c <= 60 && dc < 0; c++) begin
            @(negedge clk);
            check("busy", 64'(busy), 64'd1);
            if (done) begin
                dc = c;
                check("alu_op_done", 64'(ALUOperation), 64'h0);
            end
            if (c == 1)
                check("alu_op_c1", 64'(ALUOperation),
                      o ? 64'h1 : 64'h3);
            if (c == 2 && o && b != 32'd0)
                check("alu_op_sub", 64'(ALUOperation), 64'h4);
            start     = (c == p1) || (c == p2);
            operand_a = $urandom;
            operand_b = $urandom;
            op        = 1'($urandom);
        end
        check("done_cycle", 64'(dc), 64'(exp_dc));
        check("hi", 64'(HI), 64'(eh));
        check("lo", 64'(LO), 64'(el));
        check("dz", 64'(div_by_zero), 64'(ez));
        @(negedge clk);
        start = 1'b0;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        @(negedge clk);
        check("hold", {HI, LO}, {eh, el});
        check("hold_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int saw_done;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req", 64'(alu_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        check("rst_alu", {28'd0, ALUOperation, ALU_A}, 64'd0);
        reset = 1'b0;

        run_op(32'd7, 32'd6, 1'b0, 0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0);
        run_op(32'd100, 32'd7, 1'b1, 0, 0);
        run_op(32'h8000_0000, 32'd3, 1'b1, 0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_op(32'd5, 32'd0, 1'b1, 0, 0);
        run_op(32'd2, 32'd3, 1'b0, 0, 0);
        run_op(32'd123456, 32'd789, 1'b0, 5, 33);

        for (int i = 0; i < 6; i++) begin
            run_op($urandom, $urandom, 1'b0, 0, 0);
            run_op($urandom, 32'($urandom_range(1, 1000)), 1'b1, 0, 0);
            run_op($urandom, $urandom, 1'b1, 0, 0);
        end

        // Abort a multiply mid-run
        @(negedge clk);
        start     = 1'b1;
        op        = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h1234_5678;
        saw_done  = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) saw_done = 1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        check("abort_alu", 64'(ALUOperation), 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
